// File: rtl/shift_ring_counter.sv
// Ring / Johnson shift counter with load, direction, wrap pulse and
// illegal-state detection with optional reseeding.
module shift_ring_counter #(
  parameter int WIDTH       = 4,
  parameter bit AUTOCORRECT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] RING_SEED =
    {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] JOHN_SEED = '0;

  logic             mode_q;
  logic             mode_next;
  logic [WIDTH-1:0] q_next;
  logic             wrap_next;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-2:0] edges;
  logic             fb;
  logic             legal;

  assign seed  = mode ? JOHN_SEED : RING_SEED;

  // Adjacent-bit transitions; a Johnson state has at most one.
  assign edges = q[WIDTH-2:0] ^ q[WIDTH-1:1];

  always_comb begin
    legal = 1'b0;
    if (mode) begin
      legal = ($countones(edges) <= 1);
    end else begin
      legal = ($countones(q) == 1);
    end
  end

  assign err = ~legal;

  always_comb begin
    fb      = 1'b0;
    shifted = q;
    if (dir) begin
      fb      = q[0] ^ mode;
      shifted = {fb, q[WIDTH-1:1]};
    end else begin
      fb      = q[WIDTH-1] ^ mode;
      shifted = {q[WIDTH-2:0], fb};
    end
  end

  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    mode_next = mode_q;
    if (rst || (mode != mode_q)) begin
      q_next    = seed;
      mode_next = mode;
    end else if (load) begin
      q_next = load_val;
    end else if (AUTOCORRECT && !legal) begin
      q_next = seed;
    end else if (en) begin
      q_next    = shifted;
      wrap_next = (shifted == seed);
    end
  end

  always_ff @(posedge clk) begin
    q      <= q_next;
    wrap   <= wrap_next;
    mode_q <= mode_next;
  end

endmodule

// File: tb/tb_shift_ring_counter.sv
// Bench for shift_ring_counter: directed sequences plus random stimulus
// against an arithmetic reference model, both AUTOCORRECT settings.
module tb_shift_ring_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, en, dir, mode, load;
  logic [W-1:0] load_val;
  logic [W-1:0] q_a, q_b;
  logic         wrap_a, wrap_b, err_a, err_b;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] mq [2];
  logic         mw [2];
  logic         mmq;

  always #5 clk = ~clk;

  shift_ring_counter #(.WIDTH(W), .AUTOCORRECT(1'b1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode),
    .load(load), .load_val(load_val),
    .q(q_a), .wrap(wrap_a), .err(err_a)
  );

  shift_ring_counter #(.WIDTH(W), .AUTOCORRECT(1'b0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode),
    .load(load), .load_val(load_val),
    .q(q_b), .wrap(wrap_b), .err(err_b)
  );

  function automatic logic [W-1:0] m_seed(input logic md);
    int s;
    s = md ? 0 : (1 << (W-1));
    return W'(s);
  endfunction

  function automatic logic m_legal(input logic [W-1:0] v,
                                   input logic md);
    int ones, tr;
    ones = 0;
    tr   = 0;
    for (int i = 0; i < W; i++) ones += int'(v[i]);
    for (int i = 0; i < W-1; i++) if (v[i] != v[i+1]) tr++;
    return md ? (tr <= 1) : (ones == 1);
  endfunction

  function automatic logic [W-1:0] m_shift(input logic [W-1:0] v,
                                           input logic md,
                                           input logic d);
    int x, top, bot, fb, r;
    x   = int'(v);
    top = x / (1 << (W-1));
    bot = x % 2;
    if (!d) begin
      fb = md ? 1 - top : top;
      r  = (x * 2) % (1 << W) + fb;
    end else begin
      fb = md ? 1 - bot : bot;
      r  = fb * (1 << (W-1)) + x / 2;
    end
    return W'(r);
  endfunction

  task automatic step();
    logic [W-1:0] nq [2];
    logic         nw [2];
    logic         nm;
    nm = mmq;
    for (int k = 0; k < 2; k++) begin
      nw[k] = 1'b0;
      nq[k] = mq[k];
      if (rst || mode != mmq) begin
        nq[k] = m_seed(mode);
        nm    = mode;
      end else if (load) begin
        nq[k] = load_val;
      end else if (k == 0 && !m_legal(mq[k], mode)) begin
        nq[k] = m_seed(mode);
      end else if (en) begin
        nq[k] = m_shift(mq[k], mode, dir);
        nw[k] = (nq[k] == m_seed(mode));
      end
    end
    @(posedge clk);
    #1;
    mq  = nq;
    mw  = nw;
    mmq = nm;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; en = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    mode = 1'b0;
    rst  = 1'b1;
    step();
    rst  = 1'b0;
    total++;
    if ({q_a, wrap_a, err_a, q_b, wrap_b, err_b} !==
        {4'b1000, 2'b00, 4'b1000, 2'b00}) begin
      bad++;
      $display("FAIL reset: got %b %b%b / %b %b%b want 1000 00",
               q_a, wrap_a, err_a, q_b, wrap_b, err_b);
    end
  endtask

  task automatic test_ring_up();
    logic [W-1:0] exp_q [5] = '{4'b1000, 4'b0001, 4'b0010,
                               4'b0100, 4'b1000};
    idle_inputs();
    mode = 1'b0;
    rst  = 1'b1;
    step();
    rst = 1'b0;
    en  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      total++;
      if ({q_a, wrap_a, err_a, q_b, wrap_b, err_b} !==
          {exp_q[i], (i == 4), 1'b0, exp_q[i], (i == 4), 1'b0}) begin
        bad++;
        $display("FAIL ring_up[%0d]: got %b %b%b / %b %b%b want %b %b0",
                 i, q_a, wrap_a, err_a, q_b, wrap_b, err_b,
                 exp_q[i], (i == 4));
      end
    end
  endtask

  task automatic test_johnson();
    logic [W-1:0] exp_q [9] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                               4'b1111, 4'b1110, 4'b1100, 4'b1000,
                               4'b0000};
    idle_inputs();
    mode = 1'b1;
    rst  = 1'b1;
    step();
    rst = 1'b0;
    en  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step();
      total++;
      if ({q_a, wrap_a, err_a, q_b, wrap_b, err_b} !==
          {exp_q[i], (i == 8), 1'b0, exp_q[i], (i == 8), 1'b0}) begin
        bad++;
        $display("FAIL johnson[%0d]: got %b %b%b / %b %b%b want %b %b0",
                 i, q_a, wrap_a, err_a, q_b, wrap_b, err_b,
                 exp_q[i], (i == 8));
      end
    end
  endtask

  task automatic test_ring_down_hold();
    logic [W-1:0] exp_q [8] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001,
                               4'b1000, 4'b1000, 4'b1000, 4'b1000};
    idle_inputs();
    mode = 1'b0;
    rst  = 1'b1;
    step();
    rst = 1'b0;
    en  = 1'b1;
    dir = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) en = 1'b0;
      if (i > 0) step();
      total++;
      if ({q_a, wrap_a, q_b, wrap_b} !==
          {exp_q[i], (i == 4), exp_q[i], (i == 4)}) begin
        bad++;
        $display("FAIL ring_down[%0d]: got %b %b / %b %b want %b %b",
                 i, q_a, wrap_a, q_b, wrap_b, exp_q[i], (i == 4));
      end
    end
  endtask

  task automatic test_illegal_load();
    idle_inputs();
    mode = 1'b0;
    rst  = 1'b1;
    step();
    rst      = 1'b0;
    load     = 1'b1;
    load_val = 4'b0110;
    en       = 1'b1;
    step();
    load = 1'b0;
    total++;
    if ({q_a, err_a, q_b, err_b} !== {4'b0110, 1'b1, 4'b0110, 1'b1}) begin
      bad++;
      $display("FAIL illegal_load: got %b %b / %b %b want 0110 1 / 0110 1",
               q_a, err_a, q_b, err_b);
    end
    step();
    total++;
    if ({q_a, wrap_a, err_a, q_b, err_b} !==
        {4'b1000, 2'b00, 4'b1100, 1'b1}) begin
      bad++;
      $display("FAIL autocorrect: got %b %b%b / %b %b want 1000 00 / 1100 1",
               q_a, wrap_a, err_a, q_b, err_b);
    end
    step();
    total++;
    if ({q_a, err_a, q_b, err_b} !== {4'b0001, 1'b0, 4'b1001, 1'b1}) begin
      bad++;
      $display("FAIL illegal_rotate: got %b %b / %b %b want 0001 0 / 1001 1",
               q_a, err_a, q_b, err_b);
    end
    load     = 1'b1;
    load_val = 4'b0010;
    step();
    load = 1'b0;
    total++;
    if ({q_b, err_b} !== {4'b0010, 1'b0}) begin
      bad++;
      $display("FAIL legal_load_clears: got %b %b want 0010 0", q_b, err_b);
    end
  endtask

  task automatic test_mode_change();
    idle_inputs();
    mode = 1'b0;
    rst  = 1'b1;
    step();
    rst = 1'b0;
    en  = 1'b1;
    step();
    step();
    total++;
    if (q_a !== 4'b0010) begin
      bad++;
      $display("FAIL mode_pre: got %b want 0010", q_a);
    end
    mode     = 1'b1;
    load     = 1'b1;
    load_val = 4'b0101;
    step();
    load = 1'b0;
    total++;
    if ({q_a, wrap_a, q_b, wrap_b} !== {4'b0000, 1'b0, 4'b0000, 1'b0}) begin
      bad++;
      $display("FAIL mode_reseed: got %b %b / %b %b want 0000 0",
               q_a, wrap_a, q_b, wrap_b);
    end
    step();
    step();
    total++;
    if ({q_a, err_a, q_b, err_b} !== {4'b0011, 1'b0, 4'b0011, 1'b0}) begin
      bad++;
      $display("FAIL mode_continue: got %b %b / %b %b want 0011 0",
               q_a, err_a, q_b, err_b);
    end
  endtask

  task automatic test_priority();
    idle_inputs();
    mode = 1'b0;
    rst  = 1'b1;
    step();
    rst = 1'b0;
    en  = 1'b1;
    step();
    rst      = 1'b1;
    load     = 1'b1;
    load_val = 4'b0110;
    step();
    rst = 1'b0;
    total++;
    if ({q_a, wrap_a, q_b, wrap_b} !== {4'b1000, 1'b0, 4'b1000, 1'b0}) begin
      bad++;
      $display("FAIL rst_priority: got %b %b / %b %b want 1000 0",
               q_a, wrap_a, q_b, wrap_b);
    end
    load_val = 4'b0100;
    step();
    load = 1'b0;
    total++;
    if ({q_a, wrap_a, q_b, wrap_b} !== {4'b0100, 1'b0, 4'b0100, 1'b0}) begin
      bad++;
      $display("FAIL load_priority: got %b %b / %b %b want 0100 0",
               q_a, wrap_a, q_b, wrap_b);
    end
  endtask

  task automatic test_random();
    idle_inputs();
    rst = 1'b1;
    step();
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 39) == 0);
      en       = ($urandom_range(0, 3) != 0);
      dir      = $urandom_range(0, 1);
      load     = ($urandom_range(0, 9) == 0);
      load_val = W'($urandom);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      step();
      total++;
      if ({q_a, wrap_a, err_a, q_b, wrap_b, err_b} !==
          {mq[0], mw[0], ~m_legal(mq[0], mode),
           mq[1], mw[1], ~m_legal(mq[1], mode)}) begin
        bad++;
        $display("FAIL random[%0d]: got %b %b%b / %b %b%b want %b %b%b / %b %b%b",
                 i, q_a, wrap_a, err_a, q_b, wrap_b, err_b,
                 mq[0], mw[0], ~m_legal(mq[0], mode),
                 mq[1], mw[1], ~m_legal(mq[1], mode));
      end
    end
  endtask

  initial begin
    mq[0] = '0; mq[1] = '0;
    mw[0] = 1'b0; mw[1] = 1'b0;
    mmq   = 1'b0;
    mode  = 1'b0;
    idle_inputs();
    test_reset();
    test_ring_up();
    test_johnson();
    test_ring_down_hold();
    test_illegal_load();
    test_mode_change();
    test_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
